demux1_2: RTL and testbench



---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_fifo.sv | 77 +++++++
 rtl/demux1_2.sv | 131 +++++++++++++
 tb/tb_demux1_2.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-2 demultiplexer and its output FIFOs.
//   DEMUX_WIDTH : default data word width
//   DEMUX_DEPTH : default entries per output FIFO (power of two, >= 2)
//   word_t      : data word type at the default width
//   demux_sel_t : output selector encoding
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEMUX_WIDTH = 16;
    localparam int DEMUX_DEPTH = 2;

    typedef logic [DEMUX_WIDTH-1:0] word_t;

    typedef enum logic {
        OUT0 = 1'b0,
        OUT1 = 1'b1
    } demux_sel_t;

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// -----------------------------------------------------------------------------
// demux_fifo
// Synchronous FIFO with push/pop, full/empty flags and a head-of-queue view.
// The head is read straight from the storage registers, so a word written at
// edge k is visible at the head right after edge k (no same-cycle fall-through).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push       : write push_data this cycle (ignored while full)
//   push_data  : word to write
//   pop        : retire the head this cycle (ignored while empty)
//   full       : occupancy == DEPTH
//   empty      : occupancy == 0
//   head       : oldest stored word
// -----------------------------------------------------------------------------
module demux_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] occ_r;

    logic full_s;
    logic empty_s;
    logic push_ok_s;
    logic pop_ok_s;

    assign full_s    = (occ_r == CNT_W'(DEPTH));
    assign empty_s   = (occ_r == CNT_W'(0));
    // Local guards keep the pointers coherent even if a caller violates the handshake.
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + CNT_W'(1);
                2'b01:   occ_r <= occ_r - CNT_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign head  = mem_r[rd_ptr_r];

endmodule : demux_fifo

// File: rtl/demux1_2.sv
// -----------------------------------------------------------------------------
// demux1_2
// Registered 1-to-2 demultiplexer with valid/ready handshaking. Each accepted
// word is steered into one of two independent FIFOs so a stalled consumer never
// blocks traffic to the other one.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_data/in_select  : word and destination (0 -> output 0, 1 -> output 1)
//   in_valid/in_ready  : producer handshake; in_ready = selected FIFO not full
//   dataN/validN/readyN: consumer N handshake, dataN = head of FIFO N
//   count0/count1      : accepted-word counters, present only when the
//                        DEMUX1_2_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module demux1_2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data0,
    output logic             valid0,
    input  logic             ready0,
    output logic [WIDTH-1:0] data1,
    output logic             valid1,
    input  logic             ready1
`ifdef DEMUX1_2_STATS_EN
    ,
    output logic [15:0]      count0,
    output logic [15:0]      count1
`endif
);

    demux_sel_t sel_s;
    logic       in_ready_s;
    logic       push0_s;
    logic       push1_s;
    logic       pop0_s;
    logic       pop1_s;
    logic       full0_s;
    logic       full1_s;
    logic       empty0_s;
    logic       empty1_s;

    assign sel_s = demux_sel_t'(in_select);

    // Steering: in_ready depends only on the select and registered occupancy,
    // never on ready0/ready1, so no combinational path runs consumer-to-producer.
    always_comb begin
        in_ready_s = 1'b0;
        push0_s    = 1'b0;
        push1_s    = 1'b0;
        case (sel_s)
            OUT0: begin
                in_ready_s = !full0_s;
                push0_s    = in_valid && !full0_s;
            end
            OUT1: begin
                in_ready_s = !full1_s;
                push1_s    = in_valid && !full1_s;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    assign pop0_s = !empty0_s && ready0;
    assign pop1_s = !empty1_s && ready1;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0_s),
        .push_data (in_data),
        .pop       (pop0_s),
        .full      (full0_s),
        .empty     (empty0_s),
        .head      (data0)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1_s),
        .push_data (in_data),
        .pop       (pop1_s),
        .full      (full1_s),
        .empty     (empty1_s),
        .head      (data1)
    );

    assign in_ready = in_ready_s;
    assign valid0   = !empty0_s;
    assign valid1   = !empty1_s;

`ifdef DEMUX1_2_STATS_EN
    logic [15:0] count0_r;
    logic [15:0] count1_r;

    // Per-output accepted-word counters; wrap from 16'hFFFF to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count0_r <= 16'h0000;
            count1_r <= 16'h0000;
        end else begin
            if (push0_s) begin
                count0_r <= count0_r + 16'h0001;
            end
            if (push1_s) begin
                count1_r <= count1_r + 16'h0001;
            end
        end
    end

    assign count0 = count0_r;
    assign count1 = count1_r;
`endif

endmodule : demux1_2

// File: tb/tb_demux1_2.sv
// -----------------------------------------------------------------------------
// tb_demux1_2
// Directed self-checking bench for demux1_2 (WIDTH = 16, DEPTH = 2).
// Inputs change 1 time unit after the rising edge; outputs are checked 1-2
// time units after the edge, never on it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux1_2;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_select;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data0;
    logic        valid0;
    logic        ready0;
    logic [15:0] data1;
    logic        valid1;
    logic        ready1;
`ifdef DEMUX1_2_STATS_EN
    logic [15:0] count0;
    logic [15:0] count1;
`endif

    int checks = 0;
    int errors = 0;

    demux1_2 #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data0     (data0),
        .valid0    (valid0),
        .ready0    (ready0),
        .data1     (data1),
        .valid1    (valid1),
        .ready1    (ready1)
`ifdef DEMUX1_2_STATS_EN
        ,
        .count0    (count0),
        .count1    (count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset held 2 cycles with in_valid high ----------------
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 16'hDEAD;
        ready0    = 1'b0;
        ready1    = 1'b0;
        tick();
        tick();
        chk1 ("rst_valid0", valid0, 1'b0);
        chk1 ("rst_valid1", valid1, 1'b0);
        chk16("rst_data0", data0, 16'h0000);
        chk16("rst_data1", data1, 16'h0000);
        chk1 ("rst_in_ready", in_ready, 1'b1);
`ifdef DEMUX1_2_STATS_EN
        chk16("rst_count0", count0, 16'h0000);
        chk16("rst_count1", count1, 16'h0000);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk1 ("post_rst_valid0", valid0, 1'b0);
        chk1 ("post_rst_valid1", valid1, 1'b0);
        chk16("post_rst_data0", data0, 16'h0000);
        #1;
        chk1 ("post_rst_in_ready", in_ready, 1'b1);

        // ---------------- basic route ----------------
        ready0    = 1'b1;
        ready1    = 1'b1;
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 16'hA5A5;
        tick();
        in_select = 1'b1;
        in_data   = 16'h5A5A;
        chk1 ("route_valid0", valid0, 1'b1);
        chk16("route_data0", data0, 16'hA5A5);
        chk1 ("route_valid1_early", valid1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk1 ("route_valid0_drop", valid0, 1'b0);
        chk1 ("route_valid1", valid1, 1'b1);
        chk16("route_data1", data1, 16'h5A5A);
        tick();
        chk1 ("route_valid1_drop", valid1, 1'b0);

        // ---------------- backpressure isolation ----------------
        ready0    = 1'b0;
        ready1    = 1'b0;
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 16'h1111;
        #1;
        chk1("bp_ready_w1", in_ready, 1'b1);
        tick();
        in_data = 16'h2222;
        #1;
        chk1("bp_ready_w2", in_ready, 1'b1);
        tick();
        in_data = 16'h3333;
        #1;
        chk1("bp_ready_w3_full", in_ready, 1'b0);
        tick();
        in_select = 1'b1;
        in_data   = 16'h4444;
        #1;
        chk1("bp_ready_other", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk1 ("bp_valid1", valid1, 1'b1);
        chk16("bp_data1", data1, 16'h4444);
        chk1 ("bp_valid0", valid0, 1'b1);
        chk16("bp_data0_head", data0, 16'h1111);
        ready0 = 1'b1;
        tick();
        chk1 ("bp_valid0_second", valid0, 1'b1);
        chk16("bp_data0_second", data0, 16'h2222);
        tick();
        chk1("bp_valid0_drained", valid0, 1'b0);
        ready0 = 1'b0;
        ready1 = 1'b1;
        tick();
        chk1("bp_valid1_drained", valid1, 1'b0);
        ready1 = 1'b0;

        // ---------------- ordering and pointer wrap ----------------
        ready0    = 1'b1;
        in_valid  = 1'b1;
        in_select = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            tick();
            chk1 ("wrap_valid0", valid0, 1'b1);
            chk16("wrap_data0", data0, 16'(i));
        end
        in_valid = 1'b0;
        tick();
        chk1("wrap_valid0_end", valid0, 1'b0);
        ready0 = 1'b0;

        // ---------------- simultaneous push/pop on FIFO 1 ----------------
        in_valid  = 1'b1;
        in_select = 1'b1;
        in_data   = 16'h0B00;
        tick();
        chk16("pp_data1_init", data1, 16'h0B00);
        ready1 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 16'h0B00 + 16'(i);
            tick();
            chk1 ("pp_valid1", valid1, 1'b1);
            chk16("pp_data1", data1, 16'h0B00 + 16'(i));
            chk1 ("pp_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk1("pp_valid1_single", valid1, 1'b0);
        ready1 = 1'b0;

        // ---------------- reset mid-operation ----------------
        in_valid  = 1'b1;
        in_select = 1'b0;
        in_data   = 16'hAAAA;
        tick();
        in_data = 16'hBBBB;
        tick();
        in_valid = 1'b0;
        #1;
        chk1 ("mid_full_ready", in_ready, 1'b0);
        chk16("mid_head", data0, 16'hAAAA);
`ifdef DEMUX1_2_STATS_EN
        chk16("mid_count0", count0, 16'd13);
        chk16("mid_count1", count1, 16'd8);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1 ("mid_rst_valid0", valid0, 1'b0);
        chk16("mid_rst_data0", data0, 16'h0000);
`ifdef DEMUX1_2_STATS_EN
        chk16("mid_rst_count0", count0, 16'h0000);
        chk16("mid_rst_count1", count1, 16'h0000);
`endif
        #1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk1 ("fresh_valid0", valid0, 1'b1);
        chk16("fresh_data0", data0, 16'h1234);
`ifdef DEMUX1_2_STATS_EN
        chk16("fresh_count0", count0, 16'h0001);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_demux1_2
